// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type and constants for the fetch/data memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  localparam logic [3:0] BYTE_EN_WORD = 4'hF;
  localparam int         WDOG_W       = 16;

endpackage

// File: rtl/mem_arb_wdog.sv
// rtl/mem_arb_wdog.sv - transaction watchdog: counts unacknowledged busy cycles
module mem_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  import mem_arb_pkg::*;

  localparam logic [WDOG_W:0] LIMIT = (WDOG_W + 1)'(TIMEOUT);

  logic [WDOG_W-1:0] count;
  logic [WDOG_W:0]   count_next;

  // Expire fires on the cycle whose increment makes the count reach TIMEOUT,
  // so the memory port sees exactly TIMEOUT busy cycles before the abort.
  assign count_next = {1'b0, count} + (WDOG_W + 1)'(1);
  assign expire     = en && (count_next == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WDOG_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises fetch and data requests onto one variable-latency memory port
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_Req,
  input  logic [31:0] I_Addr,
  output logic [31:0] I_Data,
  output logic        I_Valid,
  input  logic        D_Req,
  input  logic        D_W_En,
  input  logic [31:0] D_Addr,
  input  logic [31:0] D_W_Data,
  input  logic [3:0]  D_Byte_En,
  output logic [31:0] D_R_Data,
  output logic        D_Valid,
  output logic        MEM_Req,
  output logic        MEM_W_En,
  output logic [31:0] MEM_Addr,
  output logic [31:0] MEM_W_Data,
  output logic [3:0]  MEM_Byte_En,
  input  logic        MEM_Ack,
  input  logic [31:0] MEM_R_Data,
  output logic        Stall_F,
  output logic        Stall_M,
  output logic        Bus_Err
);
  import mem_arb_pkg::*;

  arb_state_t state;
  logic       d_elig;
  logic       i_elig;
  logic       busy;
  logic       ack;
  logic       abort;
  logic       grant_d;
  logic       grant_i;

  // A requester still shows its finished request during its Valid cycle.
  assign d_elig  = D_Req & ~D_Valid;
  assign i_elig  = I_Req & ~I_Valid;
  assign busy    = (state != IDLE);
  assign ack     = MEM_Req & MEM_Ack;
  assign Stall_F = I_Req & ~I_Valid;
  assign Stall_M = D_Req & ~D_Valid;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state)
      IDLE: begin
        grant_d = d_elig;
        grant_i = ~d_elig & i_elig;
      end
      I_BUSY:  grant_d = ack & d_elig;
      D_BUSY:  grant_i = ack & i_elig;
      default: ;
    endcase
  end

  mem_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (grant_d | grant_i),
    .en    (busy & ~ack),
    .expire(abort)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      MEM_Req     <= 1'b0;
      MEM_W_En    <= 1'b0;
      MEM_Addr    <= '0;
      MEM_W_Data  <= '0;
      MEM_Byte_En <= '0;
      I_Data      <= '0;
      D_R_Data    <= '0;
      I_Valid     <= 1'b0;
      D_Valid     <= 1'b0;
      Bus_Err     <= 1'b0;
    end else begin
      I_Valid <= 1'b0;
      D_Valid <= 1'b0;

      if (state == I_BUSY && (ack || abort)) begin
        I_Valid <= 1'b1;
        I_Data  <= abort ? 32'h0 : MEM_R_Data;
      end
      if (state == D_BUSY && (ack || abort)) begin
        D_Valid <= 1'b1;
        if (abort) begin
          D_R_Data <= 32'h0;
        end else if (!MEM_W_En) begin
          D_R_Data <= MEM_R_Data;
        end
      end
      if (abort) begin
        Bus_Err <= 1'b1;
      end

      // A grant on an ack edge hands the port straight to the other requester.
      if (grant_d) begin
        state       <= D_BUSY;
        MEM_Req     <= 1'b1;
        MEM_W_En    <= D_W_En;
        MEM_Addr    <= D_Addr;
        MEM_W_Data  <= D_W_Data;
        MEM_Byte_En <= D_W_En ? D_Byte_En : BYTE_EN_WORD;
      end else if (grant_i) begin
        state       <= I_BUSY;
        MEM_Req     <= 1'b1;
        MEM_W_En    <= 1'b0;
        MEM_Addr    <= I_Addr;
        MEM_Byte_En <= BYTE_EN_WORD;
      end else if (ack || abort) begin
        state   <= IDLE;
        MEM_Req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;
  localparam int TO = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        I_Req, D_Req, D_W_En, I_Valid, D_Valid;
  logic [31:0] I_Addr, I_Data, D_Addr, D_W_Data, D_R_Data;
  logic [3:0]  D_Byte_En, MEM_Byte_En;
  logic        MEM_Req, MEM_W_En, MEM_Ack;
  logic [31:0] MEM_Addr, MEM_W_Data, MEM_R_Data;
  logic        Stall_F, Stall_M, Bus_Err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .I_Req(I_Req), .I_Addr(I_Addr), .I_Data(I_Data), .I_Valid(I_Valid),
    .D_Req(D_Req), .D_W_En(D_W_En), .D_Addr(D_Addr), .D_W_Data(D_W_Data),
    .D_Byte_En(D_Byte_En), .D_R_Data(D_R_Data), .D_Valid(D_Valid),
    .MEM_Req(MEM_Req), .MEM_W_En(MEM_W_En), .MEM_Addr(MEM_Addr),
    .MEM_W_Data(MEM_W_Data), .MEM_Byte_En(MEM_Byte_En), .MEM_Ack(MEM_Ack),
    .MEM_R_Data(MEM_R_Data), .Stall_F(Stall_F), .Stall_M(Stall_M), .Bus_Err(Bus_Err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  int   checks = 0;
  int   errors = 0;
  bit   mem_on = 0, mem_rand = 0, log_on = 0, spurious = 0, rnd_on = 0;
  int   fixed_delay = 0;
  int   ack_count = 0;
  int   mem_cnt = 0, mem_dly = 0;
  txn_t i_log[$];
  txn_t d_log[$];
  logic [31:0] exp_d;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    if (a == 32'h10) return 32'h13;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Advances at least one cycle, then until the selected Valid or the bound.
  task automatic wait_valid(input bit port_d, input int max, output int waited);
    waited = 0;
    do begin
      @(negedge CLK);
      waited++;
    end while (!(port_d ? D_Valid : I_Valid) && waited < max);
  endtask

  // Memory model: acks after a fixed or random delay, logs each accepted transaction.
  initial begin
    MEM_Ack = 1'b0;
    MEM_R_Data = 32'h0;
    forever begin
      @(negedge CLK);
      MEM_Ack = 1'b0;
      if (spurious) begin
        MEM_Ack = 1'b1;
        MEM_R_Data = 32'hBAD0_BAD0;
      end else if (!MEM_Req || !mem_on) begin
        mem_cnt = 0;
      end else begin
        if (mem_cnt == 0) mem_dly = mem_rand ? int'($urandom_range(0, 3)) : fixed_delay;
        if (mem_cnt >= mem_dly) begin
          txn_t t;
          MEM_Ack = 1'b1;
          MEM_R_Data = rdata(MEM_Addr);
          ack_count++;
          t.we = MEM_W_En; t.addr = MEM_Addr; t.wdata = MEM_W_Data; t.be = MEM_Byte_En;
          if (log_on) begin
            if (MEM_Addr[31]) d_log.push_back(t);
            else i_log.push_back(t);
          end
          mem_cnt = 0;
        end else begin
          mem_cnt++;
        end
      end
    end
  end

  // Arbitration rules seen from outside: an eligible request in idle is granted next cycle, data first.
  initial begin
    bit pend_any, pend_both;
    pend_any = 0;
    pend_both = 0;
    forever begin
      @(negedge CLK);
      #2;
      if (rnd_on && pend_any) chk("rnd_grant", MEM_Req, 1);
      if (rnd_on && pend_both) chk("rnd_priority", MEM_Addr[31], 1);
      pend_any  = rnd_on && !MEM_Req && ((D_Req && !D_Valid) || (I_Req && !I_Valid));
      pend_both = rnd_on && !MEM_Req && D_Req && !D_Valid && I_Req && !I_Valid;
    end
  end

  task automatic run_i(input int n);
    logic [31:0] a;
    int w;
    txn_t t;
    for (int k = 0; k < n; k++) begin
      a = $urandom;
      a[31] = 1'b0;
      a[1:0] = 2'b00;
      I_Addr = a;
      I_Req = 1'b1;
      wait_valid(0, 100, w);
      chk("rnd_i_valid", I_Valid, 1);
      chk("rnd_i_data", I_Data, rdata(a));
      chk("rnd_i_stall", Stall_F, 0);
      if (i_log.size() == 1) begin
        t = i_log.pop_front();
        chk("rnd_i_mem_addr", t.addr, a);
        chk("rnd_i_mem_we", t.we, 0);
        chk("rnd_i_mem_be", t.be, 4'hF);
      end else begin
        chk("rnd_i_one_txn", i_log.size(), 1);
        i_log.delete();
      end
      if ($urandom_range(0, 1) == 1) begin
        I_Req = 1'b0;
        tick($urandom_range(1, 3));
      end
    end
    I_Req = 1'b0;
  endtask

  task automatic run_d(input int n);
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic        we;
    int w;
    txn_t t;
    for (int k = 0; k < n; k++) begin
      a = $urandom;
      a[31] = 1'b1;
      a[1:0] = 2'b00;
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      we = 1'($urandom_range(0, 1));
      D_Addr = a; D_W_Data = wd; D_Byte_En = be; D_W_En = we;
      D_Req = 1'b1;
      if (!we) exp_d = rdata(a);
      wait_valid(1, 100, w);
      chk("rnd_d_valid", D_Valid, 1);
      chk("rnd_d_data", D_R_Data, exp_d);
      chk("rnd_d_stall", Stall_M, 0);
      if (d_log.size() == 1) begin
        t = d_log.pop_front();
        chk("rnd_d_mem_addr", t.addr, a);
        chk("rnd_d_mem_we", t.we, we);
        chk("rnd_d_mem_be", t.be, we ? be : 4'hF);
        if (we) chk("rnd_d_mem_wdata", t.wdata, wd);
      end else begin
        chk("rnd_d_one_txn", d_log.size(), 1);
        d_log.delete();
      end
      if ($urandom_range(0, 1) == 1) begin
        D_Req = 1'b0;
        tick($urandom_range(1, 3));
      end
    end
    D_Req = 1'b0;
  endtask

  initial begin
    int n;
    int acks0;
    I_Req = 0; I_Addr = 0; D_Req = 0; D_W_En = 0; D_Addr = 0; D_W_Data = 0; D_Byte_En = 0;

    // Reset values
    tick(3);
    chk("rst_mem_req", MEM_Req, 0);
    chk("rst_mem_we", MEM_W_En, 0);
    chk("rst_mem_addr", MEM_Addr, 0);
    chk("rst_mem_be", MEM_Byte_En, 0);
    chk("rst_valids", {I_Valid, D_Valid}, 0);
    chk("rst_i_data", I_Data, 0);
    chk("rst_d_rdata", D_R_Data, 0);
    chk("rst_bus_err", Bus_Err, 0);
    chk("rst_stalls", {Stall_F, Stall_M}, 0);
    RST = 1'b1;
    tick(2);

    // Ack without a request is ignored
    spurious = 1; tick(2); spurious = 0; tick(2);
    chk("spur_mem_req", MEM_Req, 0);
    chk("spur_valids", {I_Valid, D_Valid}, 0);
    chk("spur_i_data", I_Data, 0);

    // Fetch only, ack two cycles after MEM_Req
    mem_on = 1; fixed_delay = 2;
    I_Addr = 32'h10; I_Req = 1;
    #1 chk("f_stall_pending", Stall_F, 1);
    tick(1);
    chk("f_mem_req", MEM_Req, 1);
    chk("f_mem_addr", MEM_Addr, 32'h10);
    chk("f_mem_we", MEM_W_En, 0);
    chk("f_mem_be", MEM_Byte_En, 4'hF);
    wait_valid(0, 20, n);
    chk("f_latency", n, 3);
    chk("f_valid", I_Valid, 1);
    chk("f_data", I_Data, 32'h13);
    chk("f_stall_valid", Stall_F, 0);
    I_Req = 0;
    tick(1);
    chk("f_pulse", I_Valid, 0);
    chk("f_idle", MEM_Req, 0);

    // Simultaneous requests: data first, fetch granted on the data ack edge
    fixed_delay = 0;
    D_W_En = 0; D_Addr = 32'h200; D_Req = 1; I_Addr = 32'h4; I_Req = 1;
    tick(1);
    chk("s_first_addr", MEM_Addr, 32'h200);
    chk("s_first_we", MEM_W_En, 0);
    chk("s_stall_f", Stall_F, 1);
    tick(1);
    chk("s_d_valid", D_Valid, 1);
    chk("s_d_data", D_R_Data, rdata(32'h200));
    chk("s_req_held", MEM_Req, 1);
    chk("s_second_addr", MEM_Addr, 32'h4);
    chk("s_i_not_yet", I_Valid, 0);
    D_Req = 0;
    tick(1);
    chk("s_i_valid", I_Valid, 1);
    chk("s_i_data", I_Data, rdata(32'h4));
    chk("s_idle", MEM_Req, 0);
    I_Req = 0;
    tick(1);

    // Store leaves D_R_Data holding the last load
    fixed_delay = 1;
    D_W_En = 1; D_Addr = 32'h100; D_W_Data = 32'hDEAD_BEEF; D_Byte_En = 4'b0011; D_Req = 1;
    tick(1);
    chk("st_mem_req", MEM_Req, 1);
    chk("st_mem_we", MEM_W_En, 1);
    chk("st_mem_addr", MEM_Addr, 32'h100);
    chk("st_mem_wdata", MEM_W_Data, 32'hDEAD_BEEF);
    chk("st_mem_be", MEM_Byte_En, 4'b0011);
    chk("st_stall_m", Stall_M, 1);
    wait_valid(1, 20, n);
    chk("st_latency", n, 2);
    chk("st_valid", D_Valid, 1);
    chk("st_rdata_kept", D_R_Data, rdata(32'h200));
    chk("st_stall_valid", Stall_M, 0);
    D_Req = 0; D_W_En = 0;
    tick(1);
    chk("st_pulse", D_Valid, 0);

    // Request held across Valid: masked one cycle, then re-sampled
    fixed_delay = 0;
    acks0 = ack_count;
    I_Addr = 32'h20; I_Req = 1;
    tick(2);
    chk("m_valid", I_Valid, 1);
    chk("m_req_low_valid", MEM_Req, 0);
    tick(1);
    chk("m_resample_gap", MEM_Req, 0);
    tick(1);
    chk("m_second_req", MEM_Req, 1);
    tick(1);
    chk("m_second_valid", I_Valid, 1);
    I_Req = 0;
    tick(2);
    chk("m_no_third", MEM_Req, 0);
    chk("m_ack_count", ack_count - acks0, 2);

    // Watchdog abort
    mem_on = 0;
    D_W_En = 0; D_Addr = 32'h300; D_Req = 1;
    tick(1);
    n = 0;
    while (MEM_Req && n < 40) begin
      n++;
      tick(1);
    end
    chk("to_busy_cycles", n, TO);
    chk("to_d_valid", D_Valid, 1);
    chk("to_data", D_R_Data, 0);
    chk("to_bus_err", Bus_Err, 1);
    D_Req = 0;
    tick(3);
    chk("to_pulse", D_Valid, 0);
    chk("to_err_sticky", Bus_Err, 1);

    // Asynchronous reset in the middle of a data transaction
    D_W_En = 1; D_Addr = 32'h400; D_W_Data = 32'h1234_5678; D_Byte_En = 4'hF; D_Req = 1;
    tick(2);
    chk("rb_busy", MEM_Req, 1);
    #2 RST = 0;
    #1;
    chk("rb_mem_req", MEM_Req, 0);
    chk("rb_mem_we", MEM_W_En, 0);
    chk("rb_mem_addr", MEM_Addr, 0);
    chk("rb_mem_wdata", MEM_W_Data, 0);
    chk("rb_mem_be", MEM_Byte_En, 0);
    chk("rb_bus_err", Bus_Err, 0);
    chk("rb_data", {I_Data | D_R_Data}, 0);
    D_Req = 0; D_W_En = 0;
    @(negedge CLK);
    RST = 1;
    tick(2);
    chk("rb_idle", MEM_Req, 0);

    // Randomized traffic on both ports
    mem_on = 1; mem_rand = 1; log_on = 1;
    i_log.delete(); d_log.delete();
    exp_d = 32'h0;
    rnd_on = 1;
    fork
      run_i(30);
      run_d(30);
    join
    rnd_on = 0;
    tick(4);
    chk("rnd_i_log_empty", i_log.size(), 0);
    chk("rnd_d_log_empty", d_log.size(), 0);
    chk("rnd_idle", MEM_Req, 0);
    chk("rnd_bus_err", Bus_Err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequential arbiter sharing one unified, variable-latency memory port between the instruction fetch stage and the memory (data) stage of the RV32i pipeline. It serialises requests, gives the data stage priority, and drives stall signals that replace the constant PC-enable and IF/ID stall ties in the core. A watchdog aborts transactions that the memory never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255: maximum wait in cycles for MEM_Ack before abort; range 1..65535.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- I_Req  in  1  fetch request; held with I_Addr stable until I_Valid.
- I_Addr  in  32  fetch word address.
- I_Data  out  32  fetched instruction; valid while I_Valid is high.
- I_Valid  out  1  one-cycle completion pulse, fetch port.
- D_Req  in  1  data request; held with the D_* inputs stable until D_Valid.
- D_W_En  in  1  1 = store, 0 = load.
- D_Addr  in  32  data address.
- D_W_Data  in  32  store data.
- D_Byte_En  in  4  store byte lanes.
- D_R_Data  out  32  load data; valid while D_Valid is high.
- D_Valid  out  1  one-cycle completion pulse, data port (loads and stores).
- MEM_Req  out  1  memory request.
- MEM_W_En  out  1  store strobe.
- MEM_Addr  out  32  memory address.
- MEM_W_Data  out  32  store data.
- MEM_Byte_En  out  4  byte lanes; 4'hF on fetches and loads.
- MEM_Ack  in  1  memory completion.
- MEM_R_Data  in  32  read data; valid when MEM_Ack is high.
- Stall_F  out  1  freeze PC and IF/ID.
- Stall_M  out  1  freeze the pipeline at the memory stage.
- Bus_Err  out  1  sticky timeout flag.

## Operation
- States: IDLE, I_BUSY, D_BUSY.
- IDLE:
  - D_Req → D_BUSY; the D_* fields are latched into the MEM_* registers.
  - Otherwise I_Req → I_BUSY; I_Addr is latched, MEM_W_En=0, MEM_Byte_En=4'hF.
- BUSY: MEM_Req and all MEM_* outputs are registered and held constant until the edge at which MEM_Ack=1 is sampled.
- On the ack edge:
  - The completing port's Valid is registered high for exactly one cycle.
  - Fetch or load: MEM_R_Data is captured into I_Data or D_R_Data.
  - Store: D_R_Data is unchanged.
  - The other port is checked. If it is requesting, the arbiter moves directly to its BUSY state and MEM_Req stays high with the new fields. Otherwise it returns to IDLE and MEM_Req drops.
- A port's Req is ignored in the cycle that port's Valid is high, because the requester still shows the old request. It is re-sampled the following cycle.
- Priority is data over fetch whenever both are eligible in the same cycle.
- Stall_F = I_Req & ~I_Valid. Stall_M = D_Req & ~D_Valid. Both are combinational.
- Watchdog:
  - A 16-bit counter clears on entry to a BUSY state and increments every BUSY cycle without an ack.
  - When the count reaches TIMEOUT, the transaction is aborted: MEM_Req drops and the completing port's Valid is pulsed with data 32'h0.
  - Bus_Err is set and stays set until reset.
- MEM_Ack while MEM_Req=0 is ignored.

## Timing
- Reset values (asynchronous, on RST=0): state IDLE, MEM_Req=0, MEM_W_En=0, MEM_Addr=0, MEM_W_Data=0, MEM_Byte_En=0, I_Data=0, D_R_Data=0, I_Valid=0, D_Valid=0, Bus_Err=0, watchdog=0.
- Reset mid-transaction abandons the transaction. The memory must tolerate MEM_Req falling without an ack.
- Latency:
  - Request sampled at edge 0 → MEM_Req high in cycle 1.
  - The memory may ack as early as cycle 1.
  - Ack sampled at edge k → Valid high in cycle k+1.
  - Minimum latency is 2 cycles.
- Single-port throughput peaks at one transaction per 3 cycles (Valid cycle, then a re-sample cycle).
- Alternating ports can run back-to-back, one transaction per ack.
- Simultaneous D_Req and I_Req in IDLE: data is served first; fetch is granted on the data ack edge.

## Structure
- Shared package mem_arb_pkg holds:
  - the arb_state_t enum (IDLE, I_BUSY, D_BUSY);
  - BYTE_EN_WORD = 4'hF;
  - WDOG_W = 16.
- One natural sub-module, mem_arb_wdog: the counter with clear and enable inputs and a `TIMEOUT` compare output.
- The FSM, MEM_* registers and response registers stay in the top level.

## Test plan
- Fetch only: I_Req=1, I_Addr=32'h0000_0010, memory acks 2 cycles after MEM_Req with 32'h0000_0013 → MEM_Addr=32'h10, I_Valid high for 1 cycle with I_Data=32'h13, Stall_F low in that cycle only.
- Store: D_Req=1, D_W_En=1, D_Addr=32'h100, D_W_Data=32'hDEAD_BEEF, D_Byte_En=4'b0011, ack after 1 cycle → MEM_* fields match the inputs, D_Valid pulses, D_R_Data unchanged.
- Simultaneous requests: D_Req (load, 32'h200) and I_Req (32'h4) in IDLE → data served first; on its ack edge MEM_Addr=32'h4 with MEM_Req held high; D_Valid, then I_Valid.
- Timeout: TIMEOUT=8, MEM_Ack never asserted → MEM_Req falls after 8 BUSY cycles, D_Valid pulses with 32'h0, Bus_Err=1 until reset.
- Reset in D_BUSY: RST low between edges → MEM_Req=0 immediately, all outputs at reset values, state IDLE after release.
- Valid-cycle masking: keep I_Req high across I_Valid → exactly one transaction per request; the next MEM_Req rises 2 cycles after I_Valid.
